// File: rtl/mp3_ctrl_pkg.sv
// rtl/mp3_ctrl_pkg.sv - shared types and constants for the bluetooth command path
//
// Purpose : frame parser state encoding, command opcodes and frame header byte
//           used by bt_frame_parser and bt_cmd_decoder.
// Ports   : none (package).
package mp3_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_HDR = 2'd1,
    GOT_CMD = 2'd2,
    GOT_ARG = 2'd3
  } frame_state_t;

  localparam logic [7:0] FRAME_HDR     = 8'hA5;

  localparam logic [7:0] CMD_VOL_UP    = 8'h01;
  localparam logic [7:0] CMD_VOL_DOWN  = 8'h02;
  localparam logic [7:0] CMD_SET_VOL   = 8'h03;
  localparam logic [7:0] CMD_PAUSE     = 8'h04;
  localparam logic [7:0] CMD_NEXT      = 8'h05;
  localparam logic [7:0] CMD_PRE       = 8'h06;
  localparam logic [7:0] CMD_SELECT    = 8'h07;

endpackage

// File: rtl/bt_frame_parser.sv
// rtl/bt_frame_parser.sv - 4-byte command frame parser with inter-byte timeout
//
// Purpose : recognises A5,CMD,ARG,CHK frames (CHK = CMD^ARG). On a good CHK
//           byte o_cmd_valid pulses combinationally in the CHK strobe cycle so
//           the consumer registers the result at that same clock edge.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           i_byte            - received UART byte
//           i_byte_valid      - one-cycle strobe qualifying i_byte
//           o_cmd, o_arg      - latched command and argument of current frame
//           o_cmd_valid       - frame accepted, execute o_cmd/o_arg now
//           o_err             - checksum mismatch or inter-byte timeout
module bt_frame_parser
  import mp3_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic [7:0] o_cmd,
  output logic [7:0] o_arg,
  output logic       o_cmd_valid,
  output logic       o_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  frame_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       arg_q, arg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    o_cmd_valid = 1'b0;
    o_err       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_byte_valid && (i_byte == FRAME_HDR)) begin
          state_d = GOT_HDR;
        end
      end
      GOT_HDR: begin
        if (i_byte_valid) begin
          cmd_d   = i_byte;
          cnt_d   = '0;
          state_d = GOT_CMD;
        end
      end
      GOT_CMD: begin
        if (i_byte_valid) begin
          arg_d   = i_byte;
          cnt_d   = '0;
          state_d = GOT_ARG;
        end
      end
      GOT_ARG: begin
        if (i_byte_valid) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (i_byte == (cmd_q ^ arg_q)) begin
            o_cmd_valid = 1'b1;
          end else begin
            o_err = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter holds the number of idle cycles already spent mid-frame; the
    // TIMEOUT_CYC-th consecutive idle cycle abandons the frame.
    if ((state_q != IDLE) && !i_byte_valid) begin
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        o_err   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_cmd = cmd_q;
  assign o_arg = arg_q;

endmodule

// File: rtl/bt_cmd_decoder.sv
// rtl/bt_cmd_decoder.sv - bluetooth command decoder holding player control state
//
// Purpose : executes parsed frames against volume, song index and pause state;
//           auto-advances on end of track. All outputs are registered.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           i_byte            - received UART byte
//           i_byte_valid      - one-cycle strobe qualifying i_byte
//           i_FINISH          - one-cycle end-of-track strobe from mp3
//           o_vol             - SCI_VOL word {att,att}
//           o_song_select     - current song index
//           o_pause           - 1 = paused
//           o_next, o_pre     - one-cycle song advanced / stepped back strobes
//           o_err             - one-cycle error strobe
module bt_cmd_decoder
  import mp3_ctrl_pkg::*;
#(
  parameter logic [15:0] VOL_INIT    = 16'h2020,
  parameter logic [7:0]  VOL_STEP    = 8'h08,
  parameter logic [7:0]  VOL_MAX_ATT = 8'hFE,
  parameter int          SONG_NUM    = 2,
  parameter int          SONG_W      = 1,
  parameter int          TIMEOUT_CYC = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  input  logic              i_FINISH,
  output logic [15:0]       o_vol,
  output logic [SONG_W-1:0] o_song_select,
  output logic              o_pause,
  output logic              o_next,
  output logic              o_pre,
  output logic              o_err
);

  logic [7:0] p_cmd, p_arg;
  logic       p_cmd_valid, p_err;

  bt_frame_parser #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_parser (
    .clk          (clk),
    .rst          (rst),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_cmd        (p_cmd),
    .o_arg        (p_arg),
    .o_cmd_valid  (p_cmd_valid),
    .o_err        (p_err)
  );

  logic [7:0]        att_q, att_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic              pause_q, pause_d;
  logic              next_q, next_d;
  logic              pre_q, pre_d;
  logic              err_q, err_d;

  logic [8:0]        att_sub9, att_add9;
  logic [SONG_W-1:0] song_inc, song_dec;
  logic              cmd_moves_song;

  // 9-bit intermediates: borrow in att_sub9[8] means underflow past zero.
  assign att_sub9 = {1'b0, att_q} - {1'b0, VOL_STEP};
  assign att_add9 = {1'b0, att_q} + {1'b0, VOL_STEP};

  assign song_inc = (song_q == SONG_W'(SONG_NUM - 1)) ? '0 : song_q + SONG_W'(1);
  assign song_dec = (song_q == '0) ? SONG_W'(SONG_NUM - 1) : song_q - SONG_W'(1);

  always_comb begin
    att_d          = att_q;
    song_d         = song_q;
    pause_d        = pause_q;
    next_d         = 1'b0;
    pre_d          = 1'b0;
    err_d          = p_err;
    cmd_moves_song = 1'b0;

    if (p_cmd_valid) begin
      case (p_cmd)
        CMD_VOL_UP:   att_d = att_sub9[8] ? 8'h00 : att_sub9[7:0];
        CMD_VOL_DOWN: att_d = (att_add9 > {1'b0, VOL_MAX_ATT}) ? VOL_MAX_ATT : att_add9[7:0];
        CMD_SET_VOL:  att_d = (p_arg > VOL_MAX_ATT) ? VOL_MAX_ATT : p_arg;
        CMD_PAUSE:    pause_d = ~pause_q;
        CMD_NEXT: begin
          song_d         = song_inc;
          next_d         = 1'b1;
          pause_d        = 1'b0;
          cmd_moves_song = 1'b1;
        end
        CMD_PRE: begin
          song_d         = song_dec;
          pre_d          = 1'b1;
          pause_d        = 1'b0;
          cmd_moves_song = 1'b1;
        end
        CMD_SELECT: begin
          if ({24'd0, p_arg} < SONG_NUM[31:0]) begin
            song_d         = p_arg[SONG_W-1:0];
            next_d         = 1'b1;
            pause_d        = 1'b0;
            cmd_moves_song = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end

    // End of track is dropped when a song-moving command executes this cycle.
    if (i_FINISH && !cmd_moves_song) begin
      song_d  = song_inc;
      next_d  = 1'b1;
      pause_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      att_q   <= VOL_INIT[7:0];
      song_q  <= '0;
      pause_q <= 1'b0;
      next_q  <= 1'b0;
      pre_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      att_q   <= att_d;
      song_q  <= song_d;
      pause_q <= pause_d;
      next_q  <= next_d;
      pre_q   <= pre_d;
      err_q   <= err_d;
    end
  end

  assign o_vol         = {att_q, att_q};
  assign o_song_select = song_q;
  assign o_pause       = pause_q;
  assign o_next        = next_q;
  assign o_pre         = pre_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// tb/tb_bt_cmd_decoder.sv - directed self-checking bench for bt_cmd_decoder
module tb_bt_cmd_decoder;

  localparam int TO_CYC = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        i_FINISH;
  logic [15:0] o_vol;
  logic [0:0]  o_song_select;
  logic        o_pause;
  logic        o_next;
  logic        o_pre;
  logic        o_err;

  int n_checks = 0;
  int n_pass   = 0;
  int next_cnt = 0;
  int pre_cnt  = 0;
  int err_cnt  = 0;

  bt_cmd_decoder #(
    .VOL_INIT    (16'h2020),
    .VOL_STEP    (8'h08),
    .VOL_MAX_ATT (8'hFE),
    .SONG_NUM    (2),
    .SONG_W      (1),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_byte        (i_byte),
    .i_byte_valid  (i_byte_valid),
    .i_FINISH      (i_FINISH),
    .o_vol         (o_vol),
    .o_song_select (o_song_select),
    .o_pause       (o_pause),
    .o_next        (o_next),
    .o_pre         (o_pre),
    .o_err         (o_err)
  );

  always #5 clk = ~clk;

  // Strobes are tallied once per cycle, so a strobe held two cycles counts twice.
  always @(negedge clk) begin
    if (!rst) begin
      next_cnt = next_cnt + int'(o_next);
      pre_cnt  = pre_cnt + int'(o_pre);
      err_cnt  = err_cnt + int'(o_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_byte       = b;
    i_byte_valid = 1'b1;
    @(posedge clk);
    #1;
    i_byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(a);
    send_byte(k);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    i_byte       = 8'h00;
    i_byte_valid = 1'b0;
    i_FINISH     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    check("rst_vol", o_vol, 32'h2020);
    check("rst_song", o_song_select, 0);
    check("rst_pause", o_pause, 0);
    check("rst_strobes", {o_next, o_pre, o_err}, 0);

    send_frame(8'h01, 8'h00, 8'h01);
    check("volup_1cyc", o_vol, 32'h1818);
    settle();
    check("volup_noerr", err_cnt, 0);

    send_frame(8'h03, 8'hFF, 8'hFC);
    check("setvol_clamp", o_vol, 32'hFEFE);
    send_frame(8'h02, 8'h00, 8'h02);
    check("voldn_sat", o_vol, 32'hFEFE);
    send_frame(8'h03, 8'h02, 8'h01);
    check("setvol_2", o_vol, 32'h0202);
    send_frame(8'h01, 8'h00, 8'h01);
    check("volup_floor", o_vol, 32'h0000);
    send_frame(8'h01, 8'h00, 8'h01);
    check("volup_floor2", o_vol, 32'h0000);

    send_frame(8'h05, 8'h00, 8'h05);
    check("next_0to1", o_song_select, 1);
    send_frame(8'h05, 8'h00, 8'h05);
    check("next_wrap", o_song_select, 0);
    settle();
    check("next_cnt2", next_cnt, 2);
    send_frame(8'h06, 8'h00, 8'h06);
    check("pre_wrap", o_song_select, 1);
    settle();
    check("pre_cnt1", pre_cnt, 1);

    send_frame(8'h04, 8'h00, 8'h04);
    check("pause_on", o_pause, 1);
    i_FINISH = 1'b1;
    @(posedge clk);
    #1;
    i_FINISH = 1'b0;
    settle();
    check("finish_song", o_song_select, 0);
    check("finish_next", next_cnt, 3);
    check("finish_unpause", o_pause, 0);

    send_frame(8'h05, 8'h00, 8'h00);
    settle();
    check("badchk_err", err_cnt, 1);
    check("badchk_song", o_song_select, 0);
    send_frame(8'h09, 8'h00, 8'h09);
    settle();
    check("unk_err", err_cnt, 2);

    send_frame(8'h07, 8'h01, 8'h06);
    settle();
    check("sel_song", o_song_select, 1);
    check("sel_next", next_cnt, 4);
    send_frame(8'h07, 8'h02, 8'h05);
    settle();
    check("sel_bad_err", err_cnt, 3);
    check("sel_bad_song", o_song_select, 1);

    send_byte(8'hA5);
    send_byte(8'h05);
    repeat (TO_CYC - 2) @(posedge clk);
    #1;
    check("to_early", err_cnt, 3);
    repeat (4) @(posedge clk);
    #1;
    check("to_err", err_cnt, 4);
    check("to_song", o_song_select, 1);
    send_frame(8'h05, 8'h00, 8'h05);
    settle();
    check("after_to_song", o_song_select, 0);
    check("after_to_next", next_cnt, 5);

    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h00);
    i_FINISH = 1'b1;
    send_byte(8'h05);
    i_FINISH = 1'b0;
    settle();
    check("fin_next_song", o_song_select, 1);
    check("fin_next_cnt", next_cnt, 6);

    send_byte(8'hA5);
    send_byte(8'h06);
    send_byte(8'h00);
    i_FINISH = 1'b1;
    send_byte(8'h06);
    i_FINISH = 1'b0;
    settle();
    check("fin_pre_song", o_song_select, 0);
    check("fin_pre_pre", pre_cnt, 2);
    check("fin_pre_next", next_cnt, 6);

    send_frame(8'h05, 8'h00, 8'h05);
    send_frame(8'h04, 8'h00, 8'h04);
    check("pre_rst_pause", o_pause, 1);
    send_byte(8'hA5);
    send_byte(8'h05);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_vol", o_vol, 32'h2020);
    check("mid_rst_song", o_song_select, 0);
    check("mid_rst_pause", o_pause, 0);
    send_byte(8'h00);
    send_byte(8'h05);
    repeat (3) @(posedge clk);
    #1;
    check("lone_song", o_song_select, 0);
    check("lone_next", next_cnt, 7);
    check("lone_err", err_cnt, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
